// File: rtl/accum_arbiter_if.sv
// Client-side and accumulator-side signals of the shared accumulator arbiter.
// The slave modport is the arbiter; the master modport is its environment (clients + accumulator).
interface accum_arbiter_if #(
   parameter int NUM_CLIENTS = 4,
   parameter int LEN_W       = 8
);
   logic [NUM_CLIENTS-1:0]            cl_req;
   logic [NUM_CLIENTS-1:0][LEN_W-1:0] cl_len;
   logic [NUM_CLIENTS-1:0][31:0]      cl_data;
   logic [NUM_CLIENTS-1:0]            cl_valid;
   logic [NUM_CLIENTS-1:0]            cl_ready;
   logic [NUM_CLIENTS-1:0]            cl_grant;
   logic [NUM_CLIENTS-1:0]            cl_done;
   logic [31:0]                       result;
   logic                              busy;
   logic [31:0]                       acc_data;
   logic                              acc_enable;
   logic                              acc_clear;
   logic [31:0]                       acc_accum;

   modport slave (
      input  cl_req, cl_len, cl_data, cl_valid, acc_accum,
      output cl_ready, cl_grant, cl_done, result, busy, acc_data, acc_enable, acc_clear
   );

   modport master (
      output cl_req, cl_len, cl_data, cl_valid, acc_accum,
      input  cl_ready, cl_grant, cl_done, result, busy, acc_data, acc_enable, acc_clear
   );
endinterface

// File: rtl/accum_arbiter.sv
// Round-robin arbiter time-sharing one external accumulator between NUM_CLIENTS bursts:
// clear, stream the granted client's beats, wait out accumulator latency, return the sum.
module accum_arbiter #(
   parameter int NUM_CLIENTS = 4,
   parameter int LEN_W       = 8,
   parameter int ACC_LAT     = 1
) (
   input logic            clk,
   input logic            reset,
   accum_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int DRN_W = $clog2(ACC_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
   logic [LEN_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [DRN_W-1:0]       drain_cnt_q, drain_cnt_d;
   logic [NUM_CLIENTS-1:0] cl_grant_q, cl_grant_d;
   logic [NUM_CLIENTS-1:0] cl_done_q, cl_done_d;
   logic [31:0]            result_q, result_d;
   logic [31:0]            acc_data_q, acc_data_d;
   logic                   acc_enable_q, acc_enable_d;
   logic                   acc_clear_q, acc_clear_d;

   logic                   sel_found;
   logic [IDX_W-1:0]       sel_idx;
   logic [IDX_W:0]         scan_idx;
   logic [IDX_W-1:0]       next_ptr;
   logic [NUM_CLIENTS-1:0] cl_ready;
   logic                   hs;

   // First requester at or after rr_ptr, wrapping modulo NUM_CLIENTS.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (scan_idx >= (IDX_W+1)'(NUM_CLIENTS))
            scan_idx = scan_idx - (IDX_W+1)'(NUM_CLIENTS);
         if (!sel_found && bus.cl_req[scan_idx[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx[IDX_W-1:0];
         end
      end
   end

   assign next_ptr = (gnt_idx_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
   assign cl_ready = (state_q == S_STREAM) ? cl_grant_q : '0;
   assign hs       = |(bus.cl_valid & cl_ready);

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_idx_d    = gnt_idx_q;
      beat_cnt_d   = beat_cnt_q;
      drain_cnt_d  = drain_cnt_q;
      cl_grant_d   = cl_grant_q;
      cl_done_d    = '0;
      result_d     = result_q;
      acc_data_d   = acc_data_q;
      acc_enable_d = 1'b0;
      acc_clear_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               gnt_idx_d  = sel_idx;
               cl_grant_d = NUM_CLIENTS'(1) << sel_idx;
               beat_cnt_d = bus.cl_len[sel_idx];
               state_d    = S_CLEAR;
            end
         end
         S_CLEAR: begin
            acc_clear_d = 1'b1;
            drain_cnt_d = DRN_W'(ACC_LAT - 1);
            state_d     = (beat_cnt_q != '0) ? S_STREAM : S_DRAIN;
         end
         S_STREAM: begin
            if (hs) begin
               acc_data_d   = bus.cl_data[gnt_idx_q];
               acc_enable_d = 1'b1;
               beat_cnt_d   = beat_cnt_q - LEN_W'(1);
               if (beat_cnt_q == LEN_W'(1))
                  state_d = S_DRAIN;
            end
         end
         // Let the last enable (or the clear, for empty bursts) reach acc_accum.
         S_DRAIN: begin
            if (drain_cnt_q == '0)
               state_d = S_DONE;
            else
               drain_cnt_d = drain_cnt_q - DRN_W'(1);
         end
         S_DONE: begin
            result_d   = bus.acc_accum;
            cl_done_d  = cl_grant_q;
            cl_grant_d = '0;
            rr_ptr_d   = next_ptr;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         gnt_idx_q    <= '0;
         beat_cnt_q   <= '0;
         drain_cnt_q  <= '0;
         cl_grant_q   <= '0;
         cl_done_q    <= '0;
         result_q     <= '0;
         acc_data_q   <= '0;
         acc_enable_q <= 1'b0;
         acc_clear_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_idx_q    <= gnt_idx_d;
         beat_cnt_q   <= beat_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         cl_grant_q   <= cl_grant_d;
         cl_done_q    <= cl_done_d;
         result_q     <= result_d;
         acc_data_q   <= acc_data_d;
         acc_enable_q <= acc_enable_d;
         acc_clear_q  <= acc_clear_d;
      end
   end

   assign bus.cl_ready   = cl_ready;
   assign bus.cl_grant   = cl_grant_q;
   assign bus.cl_done    = cl_done_q;
   assign bus.result     = result_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.acc_data   = acc_data_q;
   assign bus.acc_enable = acc_enable_q;
   assign bus.acc_clear  = acc_clear_q;
endmodule

// File: doc/accum_arbiter.md
Name: accum_arbiter

Overview:
- Time-shares one 32-bit accumulator datapath (data/enable/clear in, accum out) between NUM_CLIENTS requesters.
- Grants one client at a time, round-robin, for a whole burst.
- Per burst: clears the accumulator, streams the client's beats into it, waits out accumulator latency, then returns the final sum to that client with a done pulse.
- Sits between client blocks and the accumulator; owns all accumulator control.

Parameters:
NUM_CLIENTS, 4, number of requesters (2..8)
LEN_W, 8, width of per-burst beat count
ACC_LAT, 1, cycles from acc_enable/acc_clear high to acc_accum reflecting it (>=1)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous active-high reset
cl_req  input  NUM_CLIENTS  burst request per client
cl_len  input  NUM_CLIENTS*LEN_W  beat count per client, slice i; sampled at grant
cl_data  input  NUM_CLIENTS*32  beat data per client, slice i
cl_valid  input  NUM_CLIENTS  beat valid per client
cl_ready  output  NUM_CLIENTS  beat ready, only granted client
cl_grant  output  NUM_CLIENTS  one-hot grant, registered
cl_done  output  NUM_CLIENTS  one-cycle done pulse, registered
result  output  32  burst sum, valid when any cl_done high, held until next done
busy  output  1  high whenever state != IDLE
acc_data  output  32  to accumulator data, registered
acc_enable  output  1  to accumulator enable, registered
acc_clear  output  1  to accumulator clear, registered
acc_accum  input  32  accumulator output

Behaviour:
- Reset (sync, high): state IDLE, rr_ptr 0, beat/drain counters 0. All outputs 0: cl_grant, cl_done, result, acc_*, busy. cl_ready is 0 because state is IDLE. An in-flight burst is dropped with no done pulse.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - If any cl_req, select the first requester scanning from rr_ptr upward, wrapping modulo NUM_CLIENTS.
  - Register its grant, latch its cl_len into the beat counter, go to CLEAR.
- CLEAR (1 cycle): cl_grant held; acc_clear <= 1 (seen by accumulator next cycle). Next state is STREAM if len != 0, else DRAIN.
- STREAM:
  - cl_ready[g] = 1 combinationally; all other cl_ready = 0.
  - Handshake = cl_valid[g] & cl_ready[g]: acc_data <= cl_data[g]; acc_enable <= 1; decrement beat counter.
  - No handshake: acc_enable <= 0; acc_data holds.
  - After the last beat handshake, go to DRAIN.
- DRAIN: lasts ACC_LAT cycles; acc_enable <= 0, acc_clear <= 0.
- DONE (1 cycle):
  - result <= acc_accum; cl_done[g] <= 1 (visible next cycle).
  - cl_grant <= 0; rr_ptr <= g+1 mod NUM_CLIENTS; go to IDLE.
- acc_clear is high for exactly the one cycle after CLEAR and low otherwise.
- Latency: request seen in IDLE at cycle c0 with back-to-back valid gives done/result at c0 + len + ACC_LAT + 3.
- Back-to-back bursts: IDLE re-arbitrates in the same cycle done is visible. Minimum 1 idle cycle between grants.
- cl_req and cl_len are sampled only in IDLE. Dropping cl_req mid-burst is ignored; the burst completes.
- Valid from non-granted clients is ignored; no data from them reaches the accumulator.
- len 0: clear, drain, done with result 0.
- No arithmetic in this block; sum wrap-around is the accumulator's (mod 2^32); result is passed through unchanged.
- cl_grant and cl_done are always one-hot or zero.

Test Plan:
- Client 0 only, len 3, data 5,7,9, valid always high, req at c0 -> acc_clear high c2; acc_enable c3..c5; cl_done[0] at c7; result 21.
- All 4 request at once after reset, len 1, data 10/20/30/40 -> grants in order 0,1,2,3; results 10,20,30,40; one done each.
- Clients 0 and 2 hold req continuously, len 2 -> grants alternate 0,2,0,2; client 1 and 3 slices never ready.
- Client 1, len 4, valid toggling 1,0,1,0,... -> exactly 4 beats accepted, acc_enable only after handshakes, correct sum. Client 3 len 0 -> result 0, done at c0+4.
- Reset asserted mid-STREAM -> next cycle all outputs 0, no cl_done; subsequent request clears the accumulator and sums correctly.
- Data 0xFFFFFFFF then 0x00000002 -> result 0x00000001.
